// File: rtl/alu_operand_loader_pkg.sv
// Shared definitions for the operand loader and the two-operand ALU it feeds.
//   state_e          : loader FSM state encoding (3-bit)
//   OP_ADD..OP_OR    : 2-bit ALU opcode values, also decoded by the ALU itself
//   signed_overflow  : overflow rule for a captured result, from sign bits only
package alu_operand_loader_pkg;

  typedef enum logic [2:0] {
    S_A    = 3'd0,  // waiting for operand A
    S_B    = 3'd1,  // waiting for operand B
    S_OP   = 3'd2,  // waiting for the opcode word
    S_EXEC = 3'd3,  // ALU settles on registered operands, result captured at end
    S_RESP = 3'd4   // result presented until the consumer takes it
  } state_e;

  localparam logic [1:0] OP_ADD = 2'h0;
  localparam logic [1:0] OP_SUB = 2'h1;
  localparam logic [1:0] OP_AND = 2'h2;
  localparam logic [1:0] OP_OR  = 2'h3;

  // Two's-complement overflow: for add the operands share a sign and the
  // result sign differs; for sub the operands differ in sign and the result
  // sign differs from A. Logic ops never overflow.
  function automatic logic signed_overflow(input logic [1:0] sel,
                                           input logic       a_msb,
                                           input logic       b_msb,
                                           input logic       c_msb);
    logic ovf;
    ovf = 1'b0;
    case (sel)
      OP_ADD:  ovf = (a_msb == b_msb) && (c_msb != a_msb);
      OP_SUB:  ovf = (a_msb != b_msb) && (c_msb != a_msb);
      default: ovf = 1'b0;
    endcase
    return ovf;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational signed two-operand ALU driven by alu_operand_loader.
//   i_dataA, i_dataB : operands (two's complement, wrap modulo 2^N_BITS)
//   i_sel            : OP_ADD / OP_SUB / OP_AND / OP_OR
//   o_dataC          : result
module alu
  import alu_operand_loader_pkg::*;
#(
  parameter int N_BITS = 16
) (
  input  logic [N_BITS-1:0] i_dataA,
  input  logic [N_BITS-1:0] i_dataB,
  input  logic [1:0]        i_sel,
  output logic [N_BITS-1:0] o_dataC
);

  // NOTE: every output of an always_comb block gets a default first so no
  // path through the block leaves it unassigned and a latch is inferred.
  always_comb begin
    o_dataC = '0;
    case (i_sel)
      OP_ADD:  o_dataC = i_dataA + i_dataB;
      OP_SUB:  o_dataC = i_dataA - i_dataB;
      OP_AND:  o_dataC = i_dataA & i_dataB;
      default: o_dataC = i_dataA | i_dataB;
    endcase
  end

endmodule

// File: rtl/alu_operand_loader.sv
// Sequential front end for the external two-operand ALU.
// Loads A, B and an opcode word over a valid/ready stream, holds them in
// registers driving the ALU, captures the ALU result after one exec cycle and
// offers it (with a signed-overflow flag) on a valid/ready result port.
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_data/i_valid/o_ready  : input word stream (A, B, opcode in [1:0])
//   o_dataA/o_dataB/o_sel   : registered operands and opcode to the ALU
//   i_dataC                 : combinational ALU result
//   o_result/o_overflow     : captured result and overflow flag
//   o_result_valid/i_result_ready : result handshake
module alu_operand_loader
  import alu_operand_loader_pkg::*;
#(
  parameter int N_BITS = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [N_BITS-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [N_BITS-1:0] o_dataA,
  output logic [N_BITS-1:0] o_dataB,
  output logic [1:0]        o_sel,
  input  logic [N_BITS-1:0] i_dataC,
  output logic [N_BITS-1:0] o_result,
  output logic              o_overflow,
  output logic              o_result_valid,
  input  logic              i_result_ready
);

  state_e state, state_next;
  logic   accept;

  // Handshake outputs come from the state register only, so there is no
  // combinational path from i_valid or i_result_ready to them.
  assign o_ready        = (state == S_A) || (state == S_B) || (state == S_OP);
  assign o_result_valid = (state == S_RESP);
  assign accept         = i_valid && o_ready;

  // NOTE: state and data registers use non-blocking assignments so every
  // flop samples the pre-edge values of the others.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_A;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_A:     if (accept) state_next = S_B;
      S_B:     if (accept) state_next = S_OP;
      S_OP:    if (accept) state_next = S_EXEC;
      S_EXEC:  state_next = S_RESP;
      S_RESP:  if (i_result_ready) state_next = S_A;
      default: state_next = S_A;
    endcase
  end

  // Operand registers keep their values after a transaction until the next
  // accept overwrites them; reset discards any partially loaded operands.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_dataA    <= '0;
      o_dataB    <= '0;
      o_sel      <= OP_ADD;
      o_result   <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (accept && state == S_A)  o_dataA <= i_data;
      if (accept && state == S_B)  o_dataB <= i_data;
      if (accept && state == S_OP) o_sel   <= i_data[1:0];
      // The ALU has had a full cycle on the registered operands by now.
      if (state == S_EXEC) begin
        o_result   <= i_dataC;
        o_overflow <= signed_overflow(o_sel, o_dataA[N_BITS-1],
                                      o_dataB[N_BITS-1], i_dataC[N_BITS-1]);
      end
    end
  end

endmodule
